lcd_timing_gen_param: RTL and testbench

Parametrised successor to the fixed 800x480 LTM timing generator. It produces panel HD/VD/DEN strobes and pixel coordinates from a configurable timing set with selectable sync polarity. It adds a clock-enable input and line-start and frame-start pulses. It also adds a frame counter and a prefetch address port that leads DEN, so the processor's line buffer can absorb read latency. It sits between the pixel-clock domain and the ThermoProcessor buffer read port.

---
 rtl/lcd_timing_pkg.sv | 37 +++
 rtl/lcd_timing_gen_param_wrap_counter.sv | 42 ++++
 rtl/lcd_timing_gen_param.sv | 173 +++++++++++++++++
 tb/tb_lcd_timing_gen_param.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared timing description for the LCD timing generator.
// lcd_timing_t groups the eight horizontal/vertical timing fields, LTM_800x480
// holds the stock 800x480 LTM panel timing, and the helpers derive totals and
// counter widths from a timing set.
package lcd_timing_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_front;
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned v_active;
    int unsigned v_front;
    int unsigned v_sync;
    int unsigned v_back;
  } lcd_timing_t;

  localparam lcd_timing_t LTM_800x480 = '{
    h_active: 800, h_front: 40, h_sync: 1, h_back: 215,
    v_active: 480, v_front: 10, v_sync: 1, v_back: 34
  };

  function automatic int unsigned h_total(lcd_timing_t t);
    return t.h_sync + t.h_back + t.h_active + t.h_front;
  endfunction

  function automatic int unsigned v_total(lcd_timing_t t);
    return t.v_sync + t.v_back + t.v_active + t.v_front;
  endfunction

  // Bits needed to hold 0..n-1; never less than one so single-entry ranges
  // still produce a legal vector.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_timing_gen_param_wrap_counter.sv
// wrap_counter: modulo-MAX up counter.
// Ports:
//   clk     clock
//   rst     synchronous active-high reset, clears count to 0
//   en_i    advance enable
//   count_o current count, 0..MAX-1
//   carry_o high in the enabled cycle where count wraps MAX-1 -> 0
//           (combinational, so it can enable a chained counter the same edge)
module wrap_counter
  import lcd_timing_pkg::*;
#(
  parameter int unsigned MAX = 8,
  localparam int unsigned W = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         carry_o
);

  logic [W-1:0] count_q, count_d;

  assign carry_o = en_i && (count_q == W'(MAX - 1));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = carry_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lcd_timing_gen_param.sv
// lcd_timing_gen_param: parametrised LCD panel timing generator.
// Produces HD/VD sync strobes, DEN and active-pixel coordinates from a
// configurable timing set, plus a prefetch address that leads DEN by
// PREFETCH enabled cycles so a downstream line buffer can hide read latency.
// Ports:
//   clk, rst          pixel clock, synchronous active-high reset
//   en                pixel advance enable; everything but the pulses holds when low
//   hd, vd            sync strobes, asserted low when SYNC_ACTIVE_LOW=1
//   den, x, y         active-pixel flag and coordinates (0 outside active)
//   fetch_valid/x/y   den/x/y as they will appear PREFETCH enabled cycles later
//   line_start        one-clock pulse with the output of hc=0
//   frame_start       one-clock pulse with the output of hc=0, vc=0
//   frame_count       completed frames, modulo 256
// All outputs are registered: the enabled cycle that samples counter state
// (hc, vc) presents its decode on the following clock.
module lcd_timing_gen_param
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = LTM_800x480.h_active,
  parameter int unsigned H_FRONT  = LTM_800x480.h_front,
  parameter int unsigned H_SYNC   = LTM_800x480.h_sync,
  parameter int unsigned H_BACK   = LTM_800x480.h_back,
  parameter int unsigned V_ACTIVE = LTM_800x480.v_active,
  parameter int unsigned V_FRONT  = LTM_800x480.v_front,
  parameter int unsigned V_SYNC   = LTM_800x480.v_sync,
  parameter int unsigned V_BACK   = LTM_800x480.v_back,
  parameter int unsigned PREFETCH = 2,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  localparam int unsigned XW = cnt_width(H_ACTIVE),
  localparam int unsigned YW = cnt_width(V_ACTIVE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hd,
  output logic          vd,
  output logic          den,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          fetch_valid,
  output logic [XW-1:0] fetch_x,
  output logic [YW-1:0] fetch_y,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_count
);

  localparam lcd_timing_t CFG = '{
    h_active: H_ACTIVE, h_front: H_FRONT, h_sync: H_SYNC, h_back: H_BACK,
    v_active: V_ACTIVE, v_front: V_FRONT, v_sync: V_SYNC, v_back: V_BACK
  };
  localparam int unsigned H_TOTAL = h_total(CFG);
  localparam int unsigned V_TOTAL = v_total(CFG);
  localparam int unsigned H_START = H_SYNC + H_BACK;
  localparam int unsigned V_START = V_SYNC + V_BACK;
  localparam int unsigned HCW     = cnt_width(H_TOTAL);
  localparam int unsigned VCW     = cnt_width(V_TOTAL);

  if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_bad_size
    $error("lcd_timing_gen_param: H_ACTIVE, V_ACTIVE, H_SYNC and V_SYNC must be >= 1");
  end
  if (PREFETCH > H_BACK) begin : g_bad_prefetch
    $error("lcd_timing_gen_param: PREFETCH must not exceed H_BACK");
  end

  // Raster position; the vertical counter only steps on the horizontal wrap.
  logic [HCW-1:0] hc;
  logic [VCW-1:0] vc;
  logic           h_carry, v_carry;

  wrap_counter #(.MAX(H_TOTAL)) u_hcnt (
    .clk(clk), .rst(rst), .en_i(en), .count_o(hc), .carry_o(h_carry)
  );
  wrap_counter #(.MAX(V_TOTAL)) u_vcnt (
    .clk(clk), .rst(rst), .en_i(h_carry), .count_o(vc), .carry_o(v_carry)
  );

  logic [31:0] hc32, vc32, hf32;
  logic        h_act, v_act, f_act;

  assign hc32 = 32'(hc);
  assign vc32 = 32'(vc);
  // Fetch column runs PREFETCH ahead on the same line. Because PREFETCH never
  // exceeds H_BACK, a lookahead past the line end lands in the next line's
  // sync/back porch, which is never active, so no wrap or vc lookahead needed.
  assign hf32  = hc32 + PREFETCH;
  assign h_act = (hc32 >= H_START) && (hc32 < H_START + H_ACTIVE);
  assign f_act = (hf32 >= H_START) && (hf32 < H_START + H_ACTIVE);
  assign v_act = (vc32 >= V_START) && (vc32 < V_START + V_ACTIVE);

  logic          hd_q, hd_d, vd_q, vd_d, den_q, den_d, fv_q, fv_d;
  logic [XW-1:0] x_q, x_d, fx_q, fx_d;
  logic [YW-1:0] y_q, y_d, fy_q, fy_d;
  logic          ls_q, ls_d, fs_q, fs_d;
  // fcnt_q advances with the raster state; frame_count_q is its registered
  // copy so the count lines up with the hc=0, vc=0 output it belongs to.
  logic [7:0]    fcnt_q, fcnt_d, frame_count_q, frame_count_d;

  always_comb begin
    hd_d          = hd_q;
    vd_d          = vd_q;
    den_d         = den_q;
    x_d           = x_q;
    y_d           = y_q;
    fv_d          = fv_q;
    fx_d          = fx_q;
    fy_d          = fy_q;
    frame_count_d = frame_count_q;
    fcnt_d        = fcnt_q;
    // Pulses are never stretched through an en=0 stall.
    ls_d          = 1'b0;
    fs_d          = 1'b0;
    if (en) begin
      hd_d          = (hc32 < H_SYNC) ^ SYNC_ACTIVE_LOW;
      vd_d          = (vc32 < V_SYNC) ^ SYNC_ACTIVE_LOW;
      den_d         = h_act && v_act;
      x_d           = den_d ? XW'(hc32 - H_START) : '0;
      y_d           = den_d ? YW'(vc32 - V_START) : '0;
      fv_d          = f_act && v_act;
      fx_d          = fv_d ? XW'(hf32 - H_START) : '0;
      fy_d          = fv_d ? YW'(vc32 - V_START) : '0;
      ls_d          = (hc == '0);
      fs_d          = (hc == '0) && (vc == '0);
      frame_count_d = fcnt_q;
      if (v_carry) begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hd_q          <= SYNC_ACTIVE_LOW;
      vd_q          <= SYNC_ACTIVE_LOW;
      den_q         <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      fv_q          <= 1'b0;
      fx_q          <= '0;
      fy_q          <= '0;
      ls_q          <= 1'b0;
      fs_q          <= 1'b0;
      fcnt_q        <= '0;
      frame_count_q <= '0;
    end else begin
      hd_q          <= hd_d;
      vd_q          <= vd_d;
      den_q         <= den_d;
      x_q           <= x_d;
      y_q           <= y_d;
      fv_q          <= fv_d;
      fx_q          <= fx_d;
      fy_q          <= fy_d;
      ls_q          <= ls_d;
      fs_q          <= fs_d;
      fcnt_q        <= fcnt_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign hd          = hd_q;
  assign vd          = vd_q;
  assign den         = den_q;
  assign x           = x_q;
  assign y           = y_q;
  assign fetch_valid = fv_q;
  assign fetch_x     = fx_q;
  assign fetch_y     = fy_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_lcd_timing_gen_param.sv
// Bench for lcd_timing_gen_param.
// u0: small raster H 4/1/1/2 (H_TOTAL=8), V 2/1/1/1 (V_TOTAL=5), PREFETCH=1, active-low sync.
// u1: same raster, PREFETCH=0, active-high sync.
// u2: default 800x480 LTM timing.
// Raster states are indexed by s = enabled cycles since reset release (s=0 is
// the first presented state); hc = s%8, vc = (s/8)%5, frame = s/40.
module tb_lcd_timing_gen_param;

  logic clk = 1'b0;
  logic rst;
  logic en;

  always #5 clk = ~clk;

  logic       u0_hd, u0_vd, u0_den, u0_fv, u0_ls, u0_fs;
  logic [1:0] u0_x, u0_fx;
  logic [0:0] u0_y, u0_fy;
  logic [7:0] u0_fc;

  logic       u1_hd, u1_vd, u1_den, u1_fv, u1_ls, u1_fs;
  logic [1:0] u1_x, u1_fx;
  logic [0:0] u1_y, u1_fy;
  logic [7:0] u1_fc;

  logic       u2_hd, u2_vd, u2_den, u2_fv, u2_ls, u2_fs;
  logic [9:0] u2_x, u2_fx;
  logic [8:0] u2_y, u2_fy;
  logic [7:0] u2_fc;

  lcd_timing_gen_param #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(2),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .PREFETCH(1), .SYNC_ACTIVE_LOW(1'b1)
  ) u0 (
    .clk(clk), .rst(rst), .en(en), .hd(u0_hd), .vd(u0_vd), .den(u0_den),
    .x(u0_x), .y(u0_y), .fetch_valid(u0_fv), .fetch_x(u0_fx), .fetch_y(u0_fy),
    .line_start(u0_ls), .frame_start(u0_fs), .frame_count(u0_fc)
  );

  lcd_timing_gen_param #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(2),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .PREFETCH(0), .SYNC_ACTIVE_LOW(1'b0)
  ) u1 (
    .clk(clk), .rst(rst), .en(en), .hd(u1_hd), .vd(u1_vd), .den(u1_den),
    .x(u1_x), .y(u1_y), .fetch_valid(u1_fv), .fetch_x(u1_fx), .fetch_y(u1_fy),
    .line_start(u1_ls), .frame_start(u1_fs), .frame_count(u1_fc)
  );

  lcd_timing_gen_param u2 (
    .clk(clk), .rst(rst), .en(en), .hd(u2_hd), .vd(u2_vd), .den(u2_den),
    .x(u2_x), .y(u2_y), .fetch_valid(u2_fv), .fetch_x(u2_fx), .fetch_y(u2_fy),
    .line_start(u2_ls), .frame_start(u2_fs), .frame_count(u2_fc)
  );

  // Hand-computed per-column expectations for the small raster (u0 uses PREFETCH=1).
  typedef struct {
    int hc;
    int sync;  // HD asserted
    int den;   // column inside active area
    int x;
    int fv;    // column PREFETCH=1 ahead is active
    int fx;
  } hvec_t;

  typedef struct {
    int vc;
    int sync;  // VD asserted
    int den;   // line inside active area
    int y;
  } vvec_t;

  hvec_t htab[8];
  vvec_t vtab[5];

  int checks = 0;
  int passed = 0;
  int s;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare u0 and u1 against the tables for raster state st. pulses=0 means
  // the last clock was a stall, so the start pulses must be low.
  task automatic check_small(input int st, input bit pulses);
    int hc, vc, fr, d, f;
    hc = st % 8;
    vc = (st / 8) % 5;
    fr = (st / 40) % 256;
    d  = htab[hc].den & vtab[vc].den;
    f  = htab[hc].fv & vtab[vc].den;
    check("u0.hd",  u0_hd,  htab[hc].sync ? 0 : 1);
    check("u0.vd",  u0_vd,  vtab[vc].sync ? 0 : 1);
    check("u0.den", u0_den, d);
    check("u0.x",   u0_x,   d ? htab[hc].x : 0);
    check("u0.y",   u0_y,   d ? vtab[vc].y : 0);
    check("u0.fetch_valid", u0_fv, f);
    check("u0.fetch_x", u0_fx, f ? htab[hc].fx : 0);
    check("u0.fetch_y", u0_fy, f ? vtab[vc].y : 0);
    check("u0.line_start",  u0_ls, (pulses && hc == 0) ? 1 : 0);
    check("u0.frame_start", u0_fs, (pulses && hc == 0 && vc == 0) ? 1 : 0);
    check("u0.frame_count", u0_fc, fr);
    check("u1.hd",  u1_hd,  htab[hc].sync);
    check("u1.vd",  u1_vd,  vtab[vc].sync);
    check("u1.den", u1_den, d);
    check("u1.fetch_valid", u1_fv, d);
    check("u1.fetch_x", u1_fx, d ? htab[hc].x : 0);
    check("u1.fetch_y", u1_fy, d ? vtab[vc].y : 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".u0.hd"},  u0_hd, 1);
    check({tag, ".u0.vd"},  u0_vd, 1);
    check({tag, ".u0.den"}, u0_den, 0);
    check({tag, ".u0.x"},   u0_x, 0);
    check({tag, ".u0.y"},   u0_y, 0);
    check({tag, ".u0.fetch_valid"}, u0_fv, 0);
    check({tag, ".u0.fetch_x"}, u0_fx, 0);
    check({tag, ".u0.line_start"},  u0_ls, 0);
    check({tag, ".u0.frame_start"}, u0_fs, 0);
    check({tag, ".u0.frame_count"}, u0_fc, 0);
    check({tag, ".u1.hd"}, u1_hd, 0);
    check({tag, ".u1.vd"}, u1_vd, 0);
  endtask

  initial begin
    int ls_seen, den_total, first_den, first_fv, ls_total;

    //          hc sync den x  fv fx
    htab[0] = '{0, 1,   0,  0, 0, 0};
    htab[1] = '{1, 0,   0,  0, 0, 0};
    htab[2] = '{2, 0,   0,  0, 1, 0};
    htab[3] = '{3, 0,   1,  0, 1, 1};
    htab[4] = '{4, 0,   1,  1, 1, 2};
    htab[5] = '{5, 0,   1,  2, 1, 3};
    htab[6] = '{6, 0,   1,  3, 0, 0};
    htab[7] = '{7, 0,   0,  0, 0, 0};
    //          vc sync den y
    vtab[0] = '{0, 1,   0,  0};
    vtab[1] = '{1, 0,   0,  0};
    vtab[2] = '{2, 0,   1,  0};
    vtab[3] = '{3, 0,   1,  1};
    vtab[4] = '{4, 0,   0,  0};

    // Reset held with en=1: reset must win.
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset("reset");
    end
    $display("reset: hd=%0d vd=%0d den=%0d frame_count=%0d", u0_hd, u0_vd, u0_den, u0_fc);

    // One full small frame, en=1 throughout.
    rst = 1'b0;
    for (s = 0; s < 40; s++) begin
      tick();
      check_small(s, 1'b1);
      $display("vec s=%0d hc=%0d vc=%0d hd=%0d den=%0d x=%0d y=%0d fv=%0d fx=%0d ls=%0d fs=%0d",
               s, htab[s % 8].hc, vtab[(s / 8) % 5].vc, u0_hd, u0_den, u0_x, u0_y,
               u0_fv, u0_fx, u0_ls, u0_fs);
    end
    s = 39;

    // en toggling 1,0,1,0: 8 enabled cycles over 16 clocks, pulses stay 1 clock.
    ls_seen = 0;
    for (int i = 0; i < 16; i++) begin
      en = (i % 2 == 0);
      tick();
      if (en) s++;
      check_small(s, en);
      if (u0_ls) ls_seen++;
      $display("stall clk=%0d en=%0d s=%0d hd=%0d ls=%0d fs=%0d", i, en, s, u0_hd, u0_ls, u0_fs);
    end
    check("stall.line_start_clocks", ls_seen, 1);

    // Advance to x=2, y=1 (hc=5, vc=3), then reset mid-active for 3 clocks.
    en = 1'b1;
    while (s % 40 != 29) begin
      tick();
      s++;
      check_small(s, 1'b1);
    end
    check("midrst.x_before", u0_x, 2);
    check("midrst.y_before", u0_y, 1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset("midrst");
    end
    rst = 1'b0;
    tick();
    s = 0;
    check_small(s, 1'b1);
    $display("midrst release: ls=%0d fs=%0d hd=%0d vd=%0d fc=%0d", u0_ls, u0_fs, u0_hd, u0_vd, u0_fc);

    // 257 frames: frame_count at each frame_start, wrapping 255 -> 0 -> 1.
    while (s < 257 * 40) begin
      tick();
      s++;
      if (s % 40 == 0) begin
        check("frames.frame_start", u0_fs, 1);
        check("frames.frame_count", u0_fc, (s / 40) % 256);
        if (s / 40 >= 255) $display("frame %0d: frame_count=%0d", s / 40, u0_fc);
      end
    end

    // Default LTM timing: first 36 lines from reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    den_total = 0;
    ls_total  = 0;
    first_den = -1;
    first_fv  = -1;
    for (int n = 0; n < 36 * 1056; n++) begin
      tick();
      if (u2_den) den_total++;
      if (u2_ls) ls_total++;
      if (u2_den && first_den < 0) first_den = n;
      if (u2_fv && first_fv < 0) first_fv = n;
      if (n == 0) begin
        check("ltm.hd_line0", u2_hd, 0);
        check("ltm.vd_line0", u2_vd, 0);
        check("ltm.frame_start0", u2_fs, 1);
      end
      if (n == 1) begin
        check("ltm.hd_after_sync", u2_hd, 1);
        check("ltm.line_start_width", u2_ls, 0);
      end
      if (n == 1055) check("ltm.line_start_before_wrap", u2_ls, 0);
      if (n == 1056) begin
        check("ltm.line_start_1056", u2_ls, 1);
        check("ltm.vd_line1", u2_vd, 1);
        check("ltm.frame_start_line1", u2_fs, 0);
      end
      if (n == 35 * 1056 + 216 + 797) check("ltm.fetch_x_last", u2_fx, 799);
      if (n == 35 * 1056 + 216 + 799) begin
        check("ltm.x_last", u2_x, 799);
        check("ltm.y_first_row", u2_y, 0);
      end
    end
    check("ltm.den_first_row", den_total, 800);
    check("ltm.line_starts", ls_total, 36);
    check("ltm.first_den", first_den, 35 * 1056 + 216);
    check("ltm.first_fetch", first_fv, 35 * 1056 + 214);
    $display("ltm: den_cycles=%0d line_starts=%0d first_den=%0d first_fetch=%0d",
             den_total, ls_total, first_den, first_fv);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
